// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: issues RAM reads, captures words with their PC into
// a prefetch FIFO and presents them to decode through valid/ready.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              Clock,
  input  logic              ResetN,
  input  logic              MemGrant,
  output logic              MemEnable,
  output logic              MemReadWrite,
  output logic [ADDR_W-1:0] MemAddress,
  input  logic [DATA_W-1:0] MemDataIn,
  input  logic              Redirect,
  input  logic [ADDR_W-1:0] RedirectAddr,
  output logic              InstrValid,
  input  logic              InstrReady,
  output logic [DATA_W-1:0] InstrOut,
  output logic [ADDR_W-1:0] InstrPC
);

  // state | meaning
  // BOOT  | first cycle after reset, no fetch
  // RUN   | issuing a read every allowed cycle
  // WAIT  | blocked by grant, full FIFO or redirect
  // FLUSH | one idle cycle after a redirect
  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_FLUSH = 2'd3;

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [1:0]        state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              issue;
  logic              pop;

  logic [DATA_W-1:0] fifo_data [DEPTH];
  logic [ADDR_W-1:0] fifo_pc   [DEPTH];

  // Issue uses the registered count, so a same-cycle pop cannot free a slot.
  assign issue = ((state == ST_RUN) || (state == ST_WAIT)) && MemGrant &&
                 (count < CNT_W'(DEPTH)) && !Redirect;
  assign pop   = InstrValid && InstrReady;

  assign MemEnable    = issue;
  assign MemReadWrite = issue;
  assign MemAddress   = fetch_pc;

  assign InstrValid = (count != '0);
  assign InstrOut   = InstrValid ? fifo_data[rd_ptr] : '0;
  assign InstrPC    = InstrValid ? fifo_pc[rd_ptr]   : '0;

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state    <= ST_BOOT;
      fetch_pc <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (Redirect) begin
      state    <= (state == ST_BOOT) ? ST_RUN : ST_FLUSH;
      fetch_pc <= RedirectAddr;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      case (state)
        ST_BOOT:  state <= ST_RUN;
        ST_FLUSH: state <= ST_RUN;
        default:  state <= issue ? ST_RUN : ST_WAIT;
      endcase
      if (issue) begin
        wr_ptr   <= wr_ptr + PTR_W'(1);
        fetch_pc <= fetch_pc + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({issue, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the count decides what is visible.
  always_ff @(posedge Clock) begin
    if (issue) begin
      fifo_data[wr_ptr] <= MemDataIn;
      fifo_pc[wr_ptr]   <= fetch_pc;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a combinational RAM model.
module tb_instr_fetch_unit;

  logic        Clock;
  logic        ResetN;
  logic        MemGrant;
  logic        MemEnable;
  logic        MemReadWrite;
  logic [15:0] MemAddress;
  logic [31:0] MemDataIn;
  logic        Redirect;
  logic [15:0] RedirectAddr;
  logic        InstrValid;
  logic        InstrReady;
  logic [31:0] InstrOut;
  logic [15:0] InstrPC;

  int total  = 0;
  int passed = 0;

  instr_fetch_unit dut (
    .Clock(Clock),
    .ResetN(ResetN),
    .MemGrant(MemGrant),
    .MemEnable(MemEnable),
    .MemReadWrite(MemReadWrite),
    .MemAddress(MemAddress),
    .MemDataIn(MemDataIn),
    .Redirect(Redirect),
    .RedirectAddr(RedirectAddr),
    .InstrValid(InstrValid),
    .InstrReady(InstrReady),
    .InstrOut(InstrOut),
    .InstrPC(InstrPC)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // RAM word at address a holds (a+1)*0x11111111, so words 0..7 are 0x11111111..0x88888888
  function automatic logic [31:0] ramw(input logic [15:0] a);
    logic [31:0] t;
    t = {16'h0000, a} + 32'd1;
    return t * 32'h11111111;
  endfunction

  always_comb MemDataIn = ramw(MemAddress);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge Clock);
    #2;
  endtask

  initial begin
    ResetN       = 1'b0;
    MemGrant     = 1'b1;
    InstrReady   = 1'b1;
    Redirect     = 1'b0;
    RedirectAddr = 16'h0000;

    // reset values
    #3;
    chk("rst_en",    {31'd0, MemEnable},    32'd0);
    chk("rst_rw",    {31'd0, MemReadWrite}, 32'd0);
    chk("rst_addr",  {16'd0, MemAddress},   32'd0);
    chk("rst_valid", {31'd0, InstrValid},   32'd0);
    chk("rst_out",   InstrOut,              32'd0);
    chk("rst_pc",    {16'd0, InstrPC},      32'd0);

    // streaming fetch
    @(posedge Clock);
    #3 ResetN = 1'b1;
    #1 chk("boot_en", {31'd0, MemEnable}, 32'd0);
    step();
    chk("run_en0",    {31'd0, MemEnable},    32'd1);
    chk("run_rw0",    {31'd0, MemReadWrite}, 32'd1);
    chk("run_addr0",  {16'd0, MemAddress},   32'd0);
    chk("run_valid0", {31'd0, InstrValid},   32'd0);
    step();
    chk("run_valid1", {31'd0, InstrValid}, 32'd1);
    chk("run_out0",   InstrOut,            32'h11111111);
    chk("run_pc0",    {16'd0, InstrPC},    32'd0);
    chk("run_addr1",  {16'd0, MemAddress}, 32'd1);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("stream_pc",   {16'd0, InstrPC},    k);
      chk("stream_out",  InstrOut,            ramw(16'(k)));
      chk("stream_addr", {16'd0, MemAddress}, k + 1);
      chk("stream_en",   {31'd0, MemEnable},  32'd1);
    end

    // grant drop for three cycles
    MemGrant = 1'b0;
    #1;
    chk("gnt_en1",    {31'd0, MemEnable},  32'd0);
    chk("gnt_addr1",  {16'd0, MemAddress}, 32'd6);
    chk("gnt_valid1", {31'd0, InstrValid}, 32'd1);
    chk("gnt_pc1",    {16'd0, InstrPC},    32'd5);
    step();
    chk("gnt_en2",    {31'd0, MemEnable},  32'd0);
    chk("gnt_valid2", {31'd0, InstrValid}, 32'd0);
    chk("gnt_addr2",  {16'd0, MemAddress}, 32'd6);
    step();
    chk("gnt_en3", {31'd0, MemEnable}, 32'd0);
    step();
    MemGrant = 1'b1;
    #1;
    chk("gnt_resume_en",   {31'd0, MemEnable},  32'd1);
    chk("gnt_resume_addr", {16'd0, MemAddress}, 32'd6);
    step();
    chk("gnt_next_pc",  {16'd0, InstrPC},    32'd6);
    chk("gnt_next_out", InstrOut,            ramw(16'd6));
    chk("gnt_next_addr",{16'd0, MemAddress}, 32'd7);

    // async reset mid-cycle with FIFO non-empty
    #1 ResetN = 1'b0;
    #1;
    chk("arst_valid", {31'd0, InstrValid}, 32'd0);
    chk("arst_en",    {31'd0, MemEnable},  32'd0);
    chk("arst_addr",  {16'd0, MemAddress}, 32'd0);
    InstrReady = 1'b0;
    step();
    ResetN = 1'b1;
    #1 chk("arst_boot_en", {31'd0, MemEnable}, 32'd0);

    // fill with decode stalled
    step();
    chk("fill_en0",   {31'd0, MemEnable},  32'd1);
    chk("fill_addr0", {16'd0, MemAddress}, 32'd0);
    step();
    chk("fill_valid", {31'd0, InstrValid}, 32'd1);
    chk("fill_pc0",   {16'd0, InstrPC},    32'd0);
    chk("fill_addr1", {16'd0, MemAddress}, 32'd1);
    step();
    chk("fill_addr2", {16'd0, MemAddress}, 32'd2);
    chk("fill_en2",   {31'd0, MemEnable},  32'd1);
    step();
    chk("fill_addr3", {16'd0, MemAddress}, 32'd3);
    chk("fill_en3",   {31'd0, MemEnable},  32'd1);
    step();
    chk("full_en",    {31'd0, MemEnable},  32'd0);
    chk("full_valid", {31'd0, InstrValid}, 32'd1);
    chk("full_out",   InstrOut,            32'h11111111);
    chk("full_pc",    {16'd0, InstrPC},    32'd0);
    step();
    chk("hold_en",  {31'd0, MemEnable}, 32'd0);
    chk("hold_out", InstrOut,           32'h11111111);
    InstrReady = 1'b1;
    #1 chk("full_pop_no_issue", {31'd0, MemEnable}, 32'd0);
    step();
    chk("refill_en",   {31'd0, MemEnable},  32'd1);
    chk("refill_addr", {16'd0, MemAddress}, 32'd4);
    chk("refill_pc",   {16'd0, InstrPC},    32'd1);
    step();
    chk("pre_redir_pc",   {16'd0, InstrPC},    32'd2);
    chk("pre_redir_addr", {16'd0, MemAddress}, 32'd5);

    // redirect with PCs 2..4 queued
    Redirect     = 1'b1;
    RedirectAddr = 16'h0040;
    #1 chk("redir_en", {31'd0, MemEnable}, 32'd0);
    step();
    Redirect = 1'b0;
    #1;
    chk("flush_valid", {31'd0, InstrValid}, 32'd0);
    chk("flush_en",    {31'd0, MemEnable},  32'd0);
    step();
    chk("redir_issue_en",   {31'd0, MemEnable},  32'd1);
    chk("redir_issue_addr", {16'd0, MemAddress}, 32'h0040);
    step();
    chk("redir_pc",  {16'd0, InstrPC}, 32'h0040);
    chk("redir_out", InstrOut,         ramw(16'h0040));

    // back-to-back redirects, last one wins, then PC wrap
    Redirect     = 1'b1;
    RedirectAddr = 16'h1234;
    #1 chk("b2b_en1", {31'd0, MemEnable}, 32'd0);
    step();
    RedirectAddr = 16'hFFFE;
    #1;
    chk("b2b_en2",    {31'd0, MemEnable},  32'd0);
    chk("b2b_valid2", {31'd0, InstrValid}, 32'd0);
    step();
    Redirect = 1'b0;
    #1 chk("b2b_flush_en", {31'd0, MemEnable}, 32'd0);
    step();
    chk("wrap_addr0", {16'd0, MemAddress}, 32'h0000FFFE);
    chk("wrap_en0",   {31'd0, MemEnable},  32'd1);
    step();
    chk("wrap_pc_fffe",  {16'd0, InstrPC}, 32'h0000FFFE);
    chk("wrap_out_fffe", InstrOut,         ramw(16'hFFFE));
    step();
    chk("wrap_pc_ffff",  {16'd0, InstrPC}, 32'h0000FFFF);
    chk("wrap_out_ffff", InstrOut,         32'h11110000);
    step();
    chk("wrap_pc_0000",  {16'd0, InstrPC}, 32'h00000000);
    chk("wrap_out_0000", InstrOut,         32'h11111111);
    step();
    chk("wrap_pc_0001",  {16'd0, InstrPC}, 32'h00000001);
    chk("wrap_out_0001", InstrOut,         32'h22222222);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction fetch stage directly upstream of the processor's 32-bit RAM.
- Drives the RAM's Enable/ReadWrite/Address inputs and captures its DataOut.
- Pushes fetched words with their PC into a small prefetch FIFO.
- Hands the words to decode through a valid/ready handshake, and supports branch redirect (flush) and RAM arbitration (grant).

Parameters:
- ADDR_W, 16, RAM word-address width.
- DATA_W, 32, instruction/data width.
- DEPTH, 4, prefetch FIFO entries (power of two, >= 2).
- RESET_PC, 16'h0000, first fetch address after reset.

Ports:
- Clock  in  1  system clock, rising-edge.
- ResetN  in  1  asynchronous, active-low reset.
- MemGrant  in  1  1 = fetch may use RAM this cycle; 0 = RAM owned by the data port.
- MemEnable  out  1  to RAM Enable.
- MemReadWrite  out  1  to RAM ReadWrite (1 = read).
- MemAddress  out  ADDR_W  to RAM Address.
- MemDataIn  in  DATA_W  from RAM DataOut (combinational read, valid in the cycle the address is driven).
- Redirect  in  1  branch/jump taken; flush and refetch.
- RedirectAddr  in  ADDR_W  new fetch PC.
- InstrValid  out  1  FIFO head valid.
- InstrReady  in  1  decode accepts the head.
- InstrOut  out  DATA_W  head instruction word.
- InstrPC  out  ADDR_W  address of InstrOut.

Behaviour:
- Reset (ResetN=0, async):
  - State=BOOT, FetchPC=RESET_PC, FIFO count=0, pointers=0.
  - MemEnable=0, MemReadWrite=0, MemAddress=0.
  - InstrValid=0, InstrOut=0, InstrPC=0.
- FSM:
  - BOOT: one cycle with no fetch, then -> RUN.
  - RUN: issue a read every cycle while allowed; -> WAIT when not allowed.
  - WAIT: MemEnable=0; -> RUN when allowed again.
  - FLUSH: entered on Redirect from any state except BOOT; lasts one cycle with no fetch, then -> RUN.
- Issue condition (allowed): state in {RUN, WAIT}, MemGrant=1, registered count < DEPTH, Redirect=0.
- Issue outputs (combinational from registered state plus MemGrant/Redirect): MemEnable=1, MemReadWrite=1, MemAddress=FetchPC.
- When not issuing: MemEnable=0, MemReadWrite=0, MemAddress holds FetchPC.
- Capture: at the rising edge ending an issue cycle, push {FetchPC, MemDataIn} into the FIFO and set FetchPC <= FetchPC+1.
- Latency: issue in cycle N -> InstrValid=1 with that word in cycle N+1 (if the FIFO was empty).
- PC arithmetic: modulo 2^ADDR_W; 16'hFFFF+1 wraps to 16'h0000 with no error.
- Handshake:
  - Pop on the edge where InstrValid & InstrReady.
  - InstrOut/InstrPC stay stable while InstrValid=1 and InstrReady=0.
  - InstrValid never depends combinationally on InstrReady.
- FIFO full: no issue; a pop in the same cycle does not enable an issue that cycle (count is registered). Fetch resumes the next cycle.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Redirect (sampled at the edge):
  - Count and pointers clear; FetchPC <= RedirectAddr; state -> FLUSH.
  - No issue in the Redirect cycle (MemEnable=0).
  - A head popped in the same cycle counts as consumed.
  - Redirect overrides issue, push, and MemGrant.
  - Redirect during BOOT: FetchPC is loaded and the FSM still goes to RUN.
  - Back-to-back Redirects: the last one wins.
- MemGrant drop: no issue that cycle; FIFO contents and the handshake are unaffected.
- Async reset mid-operation: immediate return to reset values; FIFO contents are discarded.

Test Plan:
1. RAM preloaded with 0x11111111.. at words 0..7; InstrReady=1, MemGrant=1; release reset -> MemEnable=0 in BOOT, then MemAddress 0,1,2,... on consecutive cycles; InstrOut/InstrPC = (0x11111111,0),(0x22222222,1)... one per cycle, starting one cycle after the first issue.
2. InstrReady=0 from reset -> exactly 4 issues (addresses 0..3), then MemEnable=0 and InstrValid=1 with InstrOut=word0 held; raise InstrReady -> fetch of address 4 starts the cycle after the first pop.
3. With the FIFO holding PCs 2..4, pulse Redirect with RedirectAddr=16'h0040 -> next cycle InstrValid=0 and MemEnable=0 (FLUSH); the following cycle MemAddress=16'h0040; the first InstrPC after that is 0x0040, and no PC 2..4 ever appears.
4. MemGrant=0 for 3 cycles mid-stream -> MemEnable=0 for exactly those cycles; the PC sequence continues without gaps or duplicates.
5. Redirect to 16'hFFFE, InstrReady=1 -> InstrPC sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
6. Assert ResetN=0 asynchronously between edges with the FIFO non-empty -> InstrValid and MemEnable drop immediately; after release, fetch restarts at RESET_PC.
